// File: rtl/addsub_accumulator_if.sv
// ---------------------------------------------------------------------------
// addsub_accumulator_if
// Purpose : groups the request/result handshake of the add/subtract
//           accumulator into one bundle.
// Signals : in_valid/in_ready/in_data/in_mode/in_clr  - request channel
//           out_valid/out_ready                       - result channel
//           out_acc/out_carry/out_ovf/out_zero/out_neg - result payload
// Modports: slave  - the accumulator side
//           master - the requester / consumer side
// ---------------------------------------------------------------------------
interface addsub_accumulator_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       in_mode;
   logic       in_clr;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_acc;
   logic       out_carry;
   logic       out_ovf;
   logic       out_zero;
   logic       out_neg;

   modport slave (
      input  in_valid, in_data, in_mode, in_clr, out_ready,
      output in_ready, out_valid, out_acc, out_carry, out_ovf, out_zero, out_neg
   );

   modport master (
      output in_valid, in_data, in_mode, in_clr, out_ready,
      input  in_ready, out_valid, out_acc, out_carry, out_ovf, out_zero, out_neg
   );
endinterface

// File: rtl/addsub_accumulator.sv
// ---------------------------------------------------------------------------
// addsub_accumulator
// Purpose : 4-bit add/subtract accumulator with a one-deep registered result
//           slot. Each accepted request updates the accumulator and produces
//           one result beat (value plus carry/overflow/zero/negative flags).
// Params  : SAT - 1 = saturate on signed overflow, 0 = wrap
// Ports   : clk   - clock, rising edge
//           rst_n - synchronous active-low reset
//           bus   - request/result handshake bundle (slave side)
// ---------------------------------------------------------------------------
module addsub_accumulator #(
   parameter int SAT = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   addsub_accumulator_if.slave         bus
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t     r_state;
   logic [3:0] r_acc;
   logic       r_carry;
   logic       r_ovf;
   logic       r_zero;
   logic       r_neg;

   logic       w_in_ready;
   logic       w_in_fire;
   logic       w_out_fire;
   logic [3:0] w_b;
   logic [4:0] w_sum;
   logic       w_ovf;
   logic [3:0] w_next;

   // Replace the wrapped sum with the signed extreme in the direction of the
   // overflow; the sign of the old accumulator tells which way it went.
   function automatic logic [3:0] sat_result(input logic [3:0] sum,
                                             input logic       ovf,
                                             input logic       acc_msb);
      logic [3:0] res;
      res = sum;
      if ((SAT != 0) && ovf) begin
         res = acc_msb ? 4'b1000 : 4'b0111;
      end
      return res;
   endfunction

   // The result slot frees up in the same cycle it is drained, so a
   // non-stalling consumer sees one result per cycle.
   assign w_in_ready = (r_state == EMPTY) || bus.out_ready;
   assign w_in_fire  = bus.in_valid && w_in_ready;
   assign w_out_fire = (r_state == FULL) && bus.out_ready;

   // Subtract is acc + ~in_data + 1, so carry=1 means no borrow.
   assign w_b    = bus.in_data ^ {4{bus.in_mode}};
   assign w_sum  = {1'b0, r_acc} + {1'b0, w_b} + {4'b0000, bus.in_mode};
   assign w_ovf  = (r_acc[3] == w_b[3]) && (w_sum[3] != r_acc[3]);
   assign w_next = sat_result(w_sum[3:0], w_ovf, r_acc[3]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= EMPTY;
         r_acc   <= 4'b0000;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b1;
         r_neg   <= 1'b0;
      end else if (w_in_fire) begin
         // A new request always refills the slot, even if the old result
         // drains this same cycle.
         r_state <= FULL;
         if (bus.in_clr) begin
            r_acc   <= 4'b0000;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b1;
            r_neg   <= 1'b0;
         end else begin
            r_acc   <= w_next;
            r_carry <= w_sum[4];
            r_ovf   <= w_ovf;
            r_zero  <= (w_next == 4'b0000);
            r_neg   <= w_next[3];
         end
      end else if (w_out_fire) begin
         r_state <= EMPTY;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = (r_state == FULL);
   assign bus.out_acc   = r_acc;
   assign bus.out_carry = r_carry;
   assign bus.out_ovf   = r_ovf;
   assign bus.out_zero  = r_zero;
   assign bus.out_neg   = r_neg;

endmodule

// File: tb/tb_addsub_accumulator.sv
// ---------------------------------------------------------------------------
// tb_addsub_accumulator
// Purpose : directed self-checking bench for addsub_accumulator. Two copies
//           run side by side on identical stimulus: u_dut0 wraps (SAT=0) and
//           u_dut1 saturates (SAT=1).
// Observed bundle per DUT: {out_valid, out_acc[3:0], carry, ovf, zero, neg}
// ---------------------------------------------------------------------------
module tb_addsub_accumulator;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   addsub_accumulator_if if0 ();
   addsub_accumulator_if if1 ();

   addsub_accumulator #(.SAT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   addsub_accumulator #(.SAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   logic [8:0] obs0;
   logic [8:0] obs1;
   assign obs0 = {if0.out_valid, if0.out_acc, if0.out_carry, if0.out_ovf, if0.out_zero, if0.out_neg};
   assign obs1 = {if1.out_valid, if1.out_acc, if1.out_carry, if1.out_ovf, if1.out_zero, if1.out_neg};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [3:0] d, input logic m,
                        input logic c, input logic ordy);
      if0.in_valid = v; if0.in_data = d; if0.in_mode = m; if0.in_clr = c; if0.out_ready = ordy;
      if1.in_valid = v; if1.in_data = d; if1.in_mode = m; if1.in_clr = c; if1.out_ready = ordy;
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 4'h7, 1'b0, 1'b0, 1'b1);
      step();
      step();
      rst_n = 1'b1;
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      #1;
      checks++;
      if (obs0 !== 9'b0_0000_0010) begin
         failures++; $display("FAIL reset_state got=%b exp=%b", obs0, 9'b0_0000_0010);
      end
      checks++;
      if (if0.in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_in_ready got=%b exp=1", if0.in_ready);
      end
   endtask

   task automatic test_add_overflow();
      drive(1'b1, 4'h5, 1'b0, 1'b0, 1'b1);
      step();
      checks++;
      if (obs0 !== {1'b1, 4'b0101, 4'b0000}) begin
         failures++; $display("FAIL add5 got=%b exp=%b", obs0, {1'b1, 4'b0101, 4'b0000});
      end
      drive(1'b1, 4'h4, 1'b0, 1'b0, 1'b1);
      step();
      checks++;
      if (obs0 !== {1'b1, 4'b1001, 4'b0101}) begin
         failures++; $display("FAIL add4_wrap got=%b exp=%b", obs0, {1'b1, 4'b1001, 4'b0101});
      end
      checks++;
      if (obs1 !== {1'b1, 4'b0111, 4'b0100}) begin
         failures++; $display("FAIL add4_sat got=%b exp=%b", obs1, {1'b1, 4'b0111, 4'b0100});
      end
   endtask

   task automatic test_clear_and_idle();
      // Clear with junk operand/mode: both copies back to zero.
      drive(1'b1, 4'h9, 1'b1, 1'b1, 1'b1);
      step();
      checks++;
      if (obs0 !== {1'b1, 4'b0000, 4'b0010}) begin
         failures++; $display("FAIL clear0 got=%b exp=%b", obs0, {1'b1, 4'b0000, 4'b0010});
      end
      checks++;
      if (obs1 !== {1'b1, 4'b0000, 4'b0010}) begin
         failures++; $display("FAIL clear1 got=%b exp=%b", obs1, {1'b1, 4'b0000, 4'b0010});
      end
      // No request: result drains, junk inputs must not touch the accumulator.
      drive(1'b0, 4'hF, 1'b0, 1'b0, 1'b1);
      step();
      checks++;
      if (obs0 !== {1'b0, 4'b0000, 4'b0010}) begin
         failures++; $display("FAIL idle got=%b exp=%b", obs0, {1'b0, 4'b0000, 4'b0010});
      end
   endtask

   task automatic test_subtract();
      drive(1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
      step();
      checks++;
      if (obs0 !== {1'b1, 4'b0011, 4'b0000}) begin
         failures++; $display("FAIL add3 got=%b exp=%b", obs0, {1'b1, 4'b0011, 4'b0000});
      end
      drive(1'b1, 4'h3, 1'b1, 1'b0, 1'b1);
      step();
      checks++;
      if (obs0 !== {1'b1, 4'b0000, 4'b1010}) begin
         failures++; $display("FAIL sub3 got=%b exp=%b", obs0, {1'b1, 4'b0000, 4'b1010});
      end
      drive(1'b1, 4'h1, 1'b1, 1'b0, 1'b1);
      step();
      checks++;
      if (obs0 !== {1'b1, 4'b1111, 4'b0001}) begin
         failures++; $display("FAIL sub1 got=%b exp=%b", obs0, {1'b1, 4'b1111, 4'b0001});
      end
   endtask

   task automatic test_stall();
      // Slot is FULL holding 1111; consumer stalls while a request waits.
      drive(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (if0.in_ready !== 1'b0) begin
            failures++; $display("FAIL stall_ready[%0d] got=%b exp=0", i, if0.in_ready);
         end
         step();
         checks++;
         if (obs0 !== {1'b1, 4'b1111, 4'b0001}) begin
            failures++; $display("FAIL stall_hold[%0d] got=%b exp=%b", i, obs0, {1'b1, 4'b1111, 4'b0001});
         end
      end
      drive(1'b1, 4'h1, 1'b0, 1'b0, 1'b1);
      #1;
      checks++;
      if (if0.in_ready !== 1'b1) begin
         failures++; $display("FAIL stall_release_ready got=%b exp=1", if0.in_ready);
      end
      step();
      checks++;
      if (obs0 !== {1'b1, 4'b0000, 4'b1010}) begin
         failures++; $display("FAIL stall_release got=%b exp=%b", obs0, {1'b1, 4'b0000, 4'b1010});
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_acc0;
      logic [3:0] exp_acc1;
      logic       exp_c0;
      logic       exp_v0;
      logic       exp_v1;
      drive(1'b1, 4'h0, 1'b0, 1'b1, 1'b1);
      step();
      exp_acc0 = 4'h0;
      exp_acc1 = 4'h0;
      drive(1'b1, 4'h1, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 20; i++) begin
         step();
         exp_c0   = (exp_acc0 == 4'hF);
         exp_v0   = (exp_acc0 == 4'h7);
         exp_acc0 = exp_acc0 + 4'h1;
         exp_v1   = (exp_acc1 == 4'h7);
         if (exp_acc1 != 4'h7) exp_acc1 = exp_acc1 + 4'h1;
         checks++;
         if (obs0 !== {1'b1, exp_acc0, exp_c0, exp_v0, exp_acc0 == 4'h0, exp_acc0[3]}) begin
            failures++; $display("FAIL b2b_wrap[%0d] got=%b exp=%b", i, obs0,
                                 {1'b1, exp_acc0, exp_c0, exp_v0, exp_acc0 == 4'h0, exp_acc0[3]});
         end
         checks++;
         if (obs1 !== {1'b1, exp_acc1, 1'b0, exp_v1, 1'b0, 1'b0}) begin
            failures++; $display("FAIL b2b_sat[%0d] got=%b exp=%b", i, obs1,
                                 {1'b1, exp_acc1, 1'b0, exp_v1, 1'b0, 1'b0});
         end
      end
   endtask

   task automatic test_reset_while_full();
      drive(1'b1, 4'h2, 1'b0, 1'b0, 1'b1);
      step();
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      step();
      checks++;
      if (if0.out_valid !== 1'b1) begin
         failures++; $display("FAIL full_before_reset got=%b exp=1", if0.out_valid);
      end
      rst_n = 1'b0;
      drive(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
      step();
      rst_n = 1'b1;
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (obs0 !== 9'b0_0000_0010) begin
         failures++; $display("FAIL reset_full got=%b exp=%b", obs0, 9'b0_0000_0010);
      end
      checks++;
      if (if0.in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_full_ready got=%b exp=1", if0.in_ready);
      end
      // Accumulator truly restarted from zero.
      drive(1'b1, 4'h6, 1'b0, 1'b0, 1'b1);
      step();
      drive(1'b1, 4'hA, 1'b1, 1'b1, 1'b1);
      step();
      checks++;
      if (obs0 !== {1'b1, 4'b0000, 4'b0010}) begin
         failures++; $display("FAIL clear_after6 got=%b exp=%b", obs0, {1'b1, 4'b0000, 4'b0010});
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_add_overflow();
      test_clear_and_idle();
      test_subtract();
      test_stall();
      test_back_to_back();
      test_reset_while_full();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
